// File: rtl/dma_mem_responder.sv
// ============================================================================
// Module   : dma_mem_responder
// Purpose  : Byte-wide memory slave answering DMA MEMR/MEMW strobe cycles.
// Revision : 1.0
// ============================================================================
`default_nettype none

module dma_mem_responder #(
  parameter int          ADDR_W = 8,
  parameter logic [7:0]  BASE   = 8'h00
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  control_bus,
  input  logic [7:0]  address_A,
  input  logic [7:0]  DMA_data_bus,
  output logic [7:0]  mem_data_out,
  output logic        data_valid,
  output logic        hit,
  output logic        err,
  output logic [15:0] xfer_count
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD      = 2'd1,
    WR_DATA = 2'd2,
    HOLD    = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [15:0]   addr_q, addr_d;
  logic          addr_vld_q, addr_vld_d;
  logic          op_wr_q, op_wr_d;
  logic [7:0]    rdata_q, rdata_d;
  logic          dv_q, dv_d;
  logic          err_q, err_d;
  logic [15:0]   cnt_q, cnt_d;
  logic          mem_we;
  logic [7:0]    mem_q [DEPTH];

  logic              memr, memw, hit_w, start_w;
  logic [ADDR_W-1:0] idx;

  assign memr  = control_bus[3];
  assign memw  = control_bus[2];
  assign idx   = addr_q[ADDR_W-1:0];
  assign hit_w = addr_vld_q && (addr_q[15:8] == BASE);

  // A new address phase starts from IDLE, or from HOLD when the other strobe appears.
  assign start_w = (memr ^ memw) &&
                   ((state_q == IDLE) || ((state_q == HOLD) && (memw != op_wr_q)));

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    addr_vld_d = addr_vld_q;
    op_wr_d    = op_wr_q;
    rdata_d    = rdata_q;
    dv_d       = 1'b0;
    err_d      = 1'b0;
    cnt_d      = cnt_q;
    mem_we     = 1'b0;

    if (memr && memw) begin
      err_d   = 1'b1;
      state_d = IDLE;
    end else if (start_w) begin
      addr_d     = {DMA_data_bus, address_A};
      addr_vld_d = 1'b1;
      op_wr_d    = memw;
      state_d    = memw ? WR_DATA : RD;
    end else begin
      case (state_q)
        RD: begin
          if (hit_w) begin
            rdata_d = mem_q[idx];
            dv_d    = 1'b1;
            cnt_d   = cnt_q + 16'd1;
          end
          state_d = HOLD;
        end
        WR_DATA: begin
          if (hit_w) begin
            mem_we = 1'b1;
            cnt_d  = cnt_q + 16'd1;
          end
          state_d = HOLD;
        end
        HOLD: begin
          if (!memr && !memw) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      addr_q     <= 16'h0000;
      addr_vld_q <= 1'b0;
      op_wr_q    <= 1'b0;
      rdata_q    <= 8'h00;
      dv_q       <= 1'b0;
      err_q      <= 1'b0;
      cnt_q      <= 16'h0000;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      addr_vld_q <= addr_vld_d;
      op_wr_q    <= op_wr_d;
      rdata_q    <= rdata_d;
      dv_q       <= dv_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
    end
  end

  // Write enable derives from the async-reset state, so reset before the commit edge aborts it.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[idx] <= DMA_data_bus;
  end

  assign mem_data_out = rdata_q;
  assign data_valid   = dv_q;
  assign hit          = hit_w;
  assign err          = err_q;
  assign xfer_count   = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_dma_mem_responder.sv
// ============================================================================
// Module   : tb_dma_mem_responder
// Purpose  : Directed self-checking bench for dma_mem_responder.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_dma_mem_responder;

  logic        clk;
  logic        rst_n;
  logic [3:0]  control_bus;
  logic [7:0]  address_A;
  logic [7:0]  DMA_data_bus;
  logic [7:0]  mem_data_out;
  logic        data_valid;
  logic        hit;
  logic        err;
  logic [15:0] xfer_count;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [3:0] C_IDLE = 4'b0000;
  localparam logic [3:0] C_MEMR = 4'b1000;
  localparam logic [3:0] C_MEMW = 4'b0100;
  localparam logic [3:0] C_BOTH = 4'b1100;

  dma_mem_responder #(.ADDR_W(8), .BASE(8'h00)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .control_bus  (control_bus),
    .address_A    (address_A),
    .DMA_data_bus (DMA_data_bus),
    .mem_data_out (mem_data_out),
    .data_valid   (data_valid),
    .hit          (hit),
    .err          (err),
    .xfer_count   (xfer_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle's inputs, then sample 1 time unit after the edge.
  task automatic step(input logic [3:0] c, input logic [7:0] d, input logic [7:0] a);
    control_bus  = c;
    DMA_data_bus = d;
    address_A    = a;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] hi, input logic [7:0] lo, input logic [7:0] d);
    step(C_MEMW, hi, lo);
    step(C_MEMW, d, lo);
    step(C_IDLE, 8'h00, 8'h00);
  endtask

  task automatic rd(input string tag, input logic [7:0] hi, input logic [7:0] lo,
                    input logic [7:0] exp_d, input logic [15:0] exp_cnt);
    step(C_MEMR, hi, lo);
    check({tag, "_dv_early"}, {31'd0, data_valid}, 32'd0);
    step(C_MEMR, hi, lo);
    check({tag, "_dv"}, {31'd0, data_valid}, 32'd1);
    check({tag, "_data"}, {24'd0, mem_data_out}, {24'd0, exp_d});
    check({tag, "_cnt"}, {16'd0, xfer_count}, {16'd0, exp_cnt});
    step(C_IDLE, 8'h00, 8'h00);
    check({tag, "_dv_late"}, {31'd0, data_valid}, 32'd0);
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_data"}, {24'd0, mem_data_out}, 32'd0);
    check({tag, "_dv"},   {31'd0, data_valid},   32'd0);
    check({tag, "_hit"},  {31'd0, hit},          32'd0);
    check({tag, "_err"},  {31'd0, err},          32'd0);
    check({tag, "_cnt"},  {16'd0, xfer_count},   32'd0);
  endtask

  initial begin
    rst_n        = 1'b0;
    control_bus  = C_IDLE;
    address_A    = 8'h00;
    DMA_data_bus = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outs("rst");
    rst_n = 1'b1;
    step(C_IDLE, 8'h00, 8'h00);
    check("idle_cnt", {16'd0, xfer_count}, 32'd0);

    // Write then read at 0x0012
    step(C_MEMW, 8'h00, 8'h12);
    check("wr_hit", {31'd0, hit}, 32'd1);
    check("wr_cnt_pre", {16'd0, xfer_count}, 32'd0);
    step(C_MEMW, 8'hA5, 8'h12);
    check("wr_cnt", {16'd0, xfer_count}, 32'd1);
    step(C_IDLE, 8'h00, 8'h00);
    rd("rd12", 8'h00, 8'h12, 8'hA5, 16'd2);

    // Preload for later tests, then reset: memory must survive
    wr(8'h00, 8'h03, 8'h3C);
    wr(8'h00, 8'h05, 8'h55);
    check("preload_cnt", {16'd0, xfer_count}, 32'd4);
    rst_n = 1'b0;
    #1;
    check_reset_outs("rst2");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Memory-to-memory: read 0x0003 held two cycles, then write 0x0040
    step(C_MEMR, 8'h00, 8'h03);
    step(C_MEMR, 8'h00, 8'h03);
    check("m2m_dv", {31'd0, data_valid}, 32'd1);
    check("m2m_rdata", {24'd0, mem_data_out}, 32'h3C);
    step(C_MEMW, 8'h00, 8'h40);
    check("m2m_dv_off", {31'd0, data_valid}, 32'd0);
    check("m2m_cnt_mid", {16'd0, xfer_count}, 32'd1);
    step(C_MEMW, 8'h3C, 8'h40);
    check("m2m_cnt", {16'd0, xfer_count}, 32'd2);
    step(C_IDLE, 8'h00, 8'h00);
    rd("rd40", 8'h00, 8'h40, 8'h3C, 16'd3);

    // Miss at 0x0105
    step(C_MEMR, 8'h01, 8'h05);
    check("miss_hit", {31'd0, hit}, 32'd0);
    step(C_MEMR, 8'h01, 8'h05);
    check("miss_dv", {31'd0, data_valid}, 32'd0);
    check("miss_data", {24'd0, mem_data_out}, 32'h3C);
    check("miss_cnt", {16'd0, xfer_count}, 32'd3);
    step(C_IDLE, 8'h00, 8'h00);
    check("miss_hit_hold", {31'd0, hit}, 32'd0);
    wr(8'h01, 8'h05, 8'h77);
    check("miss_wr_cnt", {16'd0, xfer_count}, 32'd3);
    rd("rd05", 8'h00, 8'h05, 8'h55, 16'd4);

    // Illegal strobes in HOLD (read op)
    step(C_MEMR, 8'h00, 8'h40);
    step(C_MEMR, 8'h00, 8'h40);
    check("err_pre_cnt", {16'd0, xfer_count}, 32'd5);
    step(C_BOTH, 8'h00, 8'h40);
    check("err_hold", {31'd0, err}, 32'd1);
    check("err_hold_dv", {31'd0, data_valid}, 32'd0);
    check("err_hold_cnt", {16'd0, xfer_count}, 32'd5);
    step(C_IDLE, 8'h00, 8'h00);
    check("err_pulse_end", {31'd0, err}, 32'd0);

    // Illegal strobes in WR_DATA: no write, no count
    step(C_MEMW, 8'h00, 8'h40);
    step(C_BOTH, 8'hEE, 8'h40);
    check("err_wr", {31'd0, err}, 32'd1);
    check("err_wr_cnt", {16'd0, xfer_count}, 32'd5);
    step(C_IDLE, 8'h00, 8'h00);
    rd("rd40b", 8'h00, 8'h40, 8'h3C, 16'd6);

    // Reset during WR_DATA before the commit edge
    step(C_MEMW, 8'h00, 8'h12);
    DMA_data_bus = 8'hFF;
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outs("rst_mid");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(C_IDLE, 8'h00, 8'h00);
    rd("rd12b", 8'h00, 8'h12, 8'hA5, 16'd1);

    // Counter wrap
    force dut.cnt_q = 16'hFFFF;
    #1;
    release dut.cnt_q;
    #1;
    check("wrap_pre", {16'd0, xfer_count}, 32'h0000FFFF);
    rd("wrap", 8'h00, 8'h12, 8'hA5, 16'h0000);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
